// File: rtl/iq_fifo_pkg.sv
// Shared constants and sample type for the I/Q sample FIFO.
// Build option IQ_SAMPLE_FIFO_STATUS_EN adds level/overflow status (see iq_sample_fifo).
package iq_fifo_pkg;

  localparam int IQ_DATA_W  = 32;
  localparam int IQ_FIFO_AW = 9;

  // One complex sample packed into a single FIFO word, I in the upper half.
  typedef struct packed {
    logic [15:0] i;
    logic [15:0] q;
  } iq_sample_t;

endpackage

// File: rtl/iq_sample_fifo_if.sv
// Push/pull bus of the I/Q sample FIFO; master = producer/consumer side, slave = FIFO.
// With IQ_SAMPLE_FIFO_STATUS_EN defined the bus also carries o_level and o_overflow.
interface iq_sample_fifo_if
  import iq_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = IQ_DATA_W,
  parameter int ADDR_WIDTH = IQ_FIFO_AW
);

  logic                  i_wr_en;
  logic [DATA_WIDTH-1:0] i_wr_data;
  logic                  i_rd_en;
  logic [DATA_WIDTH-1:0] o_rd_data;
  logic                  o_full;
  logic                  o_empty;
`ifdef IQ_SAMPLE_FIFO_STATUS_EN
  logic [ADDR_WIDTH:0]   o_level;
  logic                  o_overflow;

  modport master (
    output i_wr_en, i_wr_data, i_rd_en,
    input  o_rd_data, o_full, o_empty, o_level, o_overflow
  );

  modport slave (
    input  i_wr_en, i_wr_data, i_rd_en,
    output o_rd_data, o_full, o_empty, o_level, o_overflow
  );
`else
  modport master (
    output i_wr_en, i_wr_data, i_rd_en,
    input  o_rd_data, o_full, o_empty
  );

  modport slave (
    input  i_wr_en, i_wr_data, i_rd_en,
    output o_rd_data, o_full, o_empty
  );
`endif

endinterface

// File: rtl/iq_fifo_ram.sv
// Simple dual-port RAM, one write port and one read port with a registered,
// enable-gated read so the last read word is held between pulls.
module iq_fifo_ram
  import iq_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = IQ_DATA_W,
  parameter int ADDR_WIDTH = IQ_FIFO_AW
) (
  input  logic                  i_clk,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_re,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];
  logic [DATA_WIDTH-1:0] r_rdata;

  // No reset on purpose: a resettable output would stop this mapping onto block RAM.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/iq_sample_fifo.sv
// Single-clock FIFO for packed I/Q samples with registered empty/full flags.
// Define IQ_SAMPLE_FIFO_STATUS_EN to add o_level and sticky o_overflow on the bus.
module iq_sample_fifo
  import iq_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = IQ_DATA_W,
  parameter int ADDR_WIDTH = IQ_FIFO_AW
) (
  input  logic            i_sys_clk,
  input  logic            i_rst_b,
  iq_sample_fifo_if.slave bus
);

  logic [ADDR_WIDTH:0]   r_wr_ptr;
  logic [ADDR_WIDTH:0]   r_rd_ptr;
  logic                  r_empty;
  logic                  r_full;
  logic                  r_rd_zero;

  logic                  w_push;
  logic                  w_pull;
  logic [ADDR_WIDTH:0]   w_wr_ptr_next;
  logic [ADDR_WIDTH:0]   w_rd_ptr_next;
  logic [DATA_WIDTH-1:0] w_ram_rdata;

  // Acceptance uses the registered flags only; requests during reset are ignored.
  assign w_push = i_rst_b && bus.i_wr_en && !r_full;
  assign w_pull = i_rst_b && bus.i_rd_en && !r_empty;

  assign w_wr_ptr_next = r_wr_ptr + {{ADDR_WIDTH{1'b0}}, w_push};
  assign w_rd_ptr_next = r_rd_ptr + {{ADDR_WIDTH{1'b0}}, w_pull};

  always_ff @(posedge i_sys_clk) begin
    if (!i_rst_b) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_empty   <= 1'b1;
      r_full    <= 1'b0;
      r_rd_zero <= 1'b1;
    end else begin
      r_wr_ptr  <= w_wr_ptr_next;
      r_rd_ptr  <= w_rd_ptr_next;
      r_empty   <= (w_wr_ptr_next == w_rd_ptr_next);
      r_full    <= (w_wr_ptr_next[ADDR_WIDTH] != w_rd_ptr_next[ADDR_WIDTH]) &&
                   (w_wr_ptr_next[ADDR_WIDTH-1:0] == w_rd_ptr_next[ADDR_WIDTH-1:0]);
      if (w_pull) begin
        r_rd_zero <= 1'b0;
      end
    end
  end

  iq_fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .i_clk   (i_sys_clk),
    .i_we    (w_push),
    .i_waddr (r_wr_ptr[ADDR_WIDTH-1:0]),
    .i_wdata (bus.i_wr_data),
    .i_re    (w_pull),
    .i_raddr (r_rd_ptr[ADDR_WIDTH-1:0]),
    .o_rdata (w_ram_rdata)
  );

  // The RAM output register has no reset, so the zero after reset is masked here
  // until the first accepted pull reloads it.
  assign bus.o_rd_data = r_rd_zero ? '0 : w_ram_rdata;
  assign bus.o_full    = r_full;
  assign bus.o_empty   = r_empty;

`ifdef IQ_SAMPLE_FIFO_STATUS_EN
  logic [ADDR_WIDTH:0] r_level;
  logic                r_overflow;

  always_ff @(posedge i_sys_clk) begin
    if (!i_rst_b) begin
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_level <= w_wr_ptr_next - w_rd_ptr_next;
      if (bus.i_wr_en && r_full) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign bus.o_level    = r_level;
  assign bus.o_overflow = r_overflow;
`endif

endmodule

// File: tb/tb_iq_sample_fifo.sv
// Randomized self-checking bench for iq_sample_fifo against a queue-based model.
// Status outputs are checked when IQ_SAMPLE_FIFO_STATUS_EN is defined.
module tb_iq_sample_fifo;
  import iq_fifo_pkg::*;

  localparam int DW    = IQ_DATA_W;
  localparam int AW    = IQ_FIFO_AW;
  localparam int DEPTH = 1 << AW;

  logic clk   = 1'b0;
  logic rst_b = 1'b0;

  always #5 clk = ~clk;

  iq_sample_fifo_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  iq_sample_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .i_sys_clk (clk),
    .i_rst_b   (rst_b),
    .bus       (bus)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  logic [DW-1:0] model_q[$];
  logic [DW-1:0] exp_rd_data = '0;
  bit          exp_overflow = 1'b0;
  bit          verbose = 1'b0;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_sample();
    iq_sample_t s;
    s.i = 16'($urandom);
    s.q = 16'($urandom);
    return s;
  endfunction

  task automatic check_outputs();
    check_val("rd_data", 64'(bus.o_rd_data), 64'(exp_rd_data));
    check_val("empty", 64'(bus.o_empty), 64'(model_q.size() == 0));
    check_val("full", 64'(bus.o_full), 64'(model_q.size() == DEPTH));
`ifdef IQ_SAMPLE_FIFO_STATUS_EN
    check_val("level", 64'(bus.o_level), 64'(model_q.size()));
    check_val("overflow", 64'(bus.o_overflow), 64'(exp_overflow));
`endif
  endtask

  // One clock of stimulus; the model decides acceptance from occupancy alone.
  task automatic cycle(input bit wr, input logic [DW-1:0] data, input bit rd);
    bit push_ok;
    bit pull_ok;
    push_ok = wr && (model_q.size() < DEPTH);
    pull_ok = rd && (model_q.size() > 0);
    if (wr && model_q.size() == DEPTH) exp_overflow = 1'b1;
    bus.i_wr_en   = wr;
    bus.i_wr_data = data;
    bus.i_rd_en   = rd;
    if (pull_ok) exp_rd_data = model_q.pop_front();
    if (push_ok) model_q.push_back(data);
    @(posedge clk);
    #1;
    if (verbose)
      $display("txn wr=%0b rd=%0b data=%08h -> rd_data=%08h empty=%0b full=%0b",
               wr, rd, data, bus.o_rd_data, bus.o_empty, bus.o_full);
    check_outputs();
    bus.i_wr_en = 1'b0;
    bus.i_rd_en = 1'b0;
  endtask

  task automatic do_reset(input bit wr, input bit rd);
    rst_b         = 1'b0;
    bus.i_wr_en   = wr;
    bus.i_rd_en   = rd;
    bus.i_wr_data = rand_sample();
    @(posedge clk);
    #1;
    rst_b        = 1'b1;
    bus.i_wr_en  = 1'b0;
    bus.i_rd_en  = 1'b0;
    model_q.delete();
    exp_rd_data  = '0;
    exp_overflow = 1'b0;
    $display("txn reset wr=%0b rd=%0b -> rd_data=%08h empty=%0b full=%0b",
             wr, rd, bus.o_rd_data, bus.o_empty, bus.o_full);
    check_outputs();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    bus.i_wr_en   = 1'b0;
    bus.i_rd_en   = 1'b0;
    bus.i_wr_data = '0;

    // Reset, idle, and a pull on an empty FIFO.
    do_reset(1'b1, 1'b1);
    do_reset(1'b0, 1'b0);
    verbose = 1'b1;
    repeat (3) cycle(1'b0, '0, 1'b0);
    cycle(1'b0, '0, 1'b1);

    // Three pushes then three pulls.
    for (int i = 1; i <= 3; i++) cycle(1'b1, 32'hA5A5_0000 + 32'(i), 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1);
    verbose = 1'b0;

    // Fill to full, overflow push, drain in order.
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, DW'(i), 1'b0);
    cycle(1'b1, 32'hDEAD_BEEF, 1'b0);
    cycle(1'b1, 32'hCAFE_F00D, 1'b1);
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b1);
    $display("txn fill/drain done, rd_data=%08h", bus.o_rd_data);

    // Steady occupancy of 5 with continuous push+pull across pointer wrap.
    do_reset(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b1, rand_sample(), 1'b0);
    for (int i = 0; i < 1000; i++) cycle(1'b1, rand_sample(), 1'b1);
    $display("txn steady-state done, rd_data=%08h", bus.o_rd_data);

    // Reset with 10 words stored while requests are active.
    do_reset(1'b0, 1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b1, rand_sample(), 1'b0);
    do_reset(1'b1, 1'b1);
    verbose = 1'b1;
    cycle(1'b1, 32'h1234_5678, 1'b0);
    cycle(1'b0, '0, 1'b1);
    verbose = 1'b0;

    // Random traffic phases with fill- and drain-biased rates.
    for (int p = 0; p < 4; p++) begin
      int wr_pct;
      int rd_pct;
      wr_pct = (p % 2 == 0) ? 85 : 20;
      rd_pct = (p % 2 == 0) ? 15 : 80;
      for (int i = 0; i < 1500; i++)
        cycle(($urandom % 100) < wr_pct, rand_sample(), ($urandom % 100) < rd_pct);
      $display("txn random phase %0d done, occupancy %0d", p, model_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
